// File: rtl/video_pattern_gen_if.sv
// Pixel bus between the timing generator, the pattern generator and the output path.
// The slave side consumes timing/config and drives RGB plus delayed sync/DE.
interface video_pattern_gen_if #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
);
  logic              vs_in;
  logic              hs_in;
  logic              hde_in;
  logic              vde_in;
  logic [X_BITS-1:0] x_in;
  logic [Y_BITS-1:0] y_in;
  logic [X_BITS-1:0] h_active;
  logic [Y_BITS-1:0] v_active;
  logic [2:0]        pattern_sel;
  logic [23:0]       solid_rgb;
  logic [7:0]        r_out;
  logic [7:0]        g_out;
  logic [7:0]        b_out;
  logic              hs_out;
  logic              vs_out;
  logic              de_out;

  modport master (
    output vs_in, hs_in, hde_in, vde_in, x_in, y_in, h_active, v_active, pattern_sel, solid_rgb,
    input  r_out, g_out, b_out, hs_out, vs_out, de_out
  );

  modport slave (
    input  vs_in, hs_in, hde_in, vde_in, x_in, y_in, h_active, v_active, pattern_sel, solid_rgb,
    output r_out, g_out, b_out, hs_out, vs_out, de_out
  );
endinterface

// File: rtl/video_pattern_gen.sv
// RGB test-pattern source behind the timing generator; 2 clk latency on RGB, sync and DE, no backpressure.
// Optional white frame border enabled by defining PATGEN_BORDER_EN.
module video_pattern_gen #(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int MBAR_W = 16
) (
  input logic               clk,
  input logic               reset,
  video_pattern_gen_if.slave vid
);
  localparam logic [X_BITS-1:0] X_ONE    = X_BITS'(1);
  localparam logic [X_BITS:0]   XW_ONE   = (X_BITS+1)'(1);
  localparam logic [X_BITS:0]   MBAR_LEN = (X_BITS+1)'(MBAR_W);

  logic              vs_d;
  logic              hde_d;
  logic [2:0]        pattern_q;
  logic [X_BITS-1:0] frame_pos;
  logic [X_BITS-1:0] bar_cnt;
  logic [2:0]        bar_idx;

  logic              frame_start;
  logic              hde_rise;
  logic [X_BITS-1:0] bar_w;
  logic [X_BITS-1:0] cnt_cur;
  logic [2:0]        idx_cur;
  logic [X_BITS:0]   fpos_inc;
  logic [X_BITS:0]   mbar_end;
  logic [23:0]       pix;
  logic [23:0]       rgb_nxt;

  logic              s1_hs;
  logic              s1_vs;
  logic              s1_de;
  logic [23:0]       s1_rgb;
`ifdef PATGEN_BORDER_EN
  logic [X_BITS-1:0] s1_x;
  logic [Y_BITS-1:0] s1_y;
`else
  logic              unused_bits;
  assign unused_bits = ^{vid.v_active, vid.y_in};
`endif

  assign frame_start = vid.vs_in & ~vs_d;
  assign hde_rise    = vid.hde_in & ~hde_d;
  assign bar_w       = vid.h_active >> 3;
  // Counter state describes the current pixel; a line start overrides it to bar 0, pixel 0.
  assign cnt_cur     = hde_rise ? '0 : bar_cnt;
  assign idx_cur     = hde_rise ? 3'd0 : bar_idx;
  assign fpos_inc    = {1'b0, frame_pos} + XW_ONE;
  assign mbar_end    = {1'b0, frame_pos} + MBAR_LEN;

  always_comb begin
    pix = 24'h000000;
    case (pattern_q)
      3'd0: pix = vid.solid_rgb;
      // Bar order white..black maps to R=~idx[1], G=~idx[2], B=~idx[0].
      3'd1: pix = {{8{~idx_cur[1]}}, {8{~idx_cur[2]}}, {8{~idx_cur[0]}}};
      3'd2: pix = (vid.x_in[5] ^ vid.y_in[5]) ? 24'hFFFFFF : 24'h000000;
      3'd3: pix = {3{vid.x_in[7:0]}};
      3'd4: pix = (({1'b0, vid.x_in} >= {1'b0, frame_pos}) && ({1'b0, vid.x_in} < mbar_end))
                  ? 24'hFFFFFF : 24'h202020;
      default: pix = 24'h000000;
    endcase
  end

  always_comb begin
    rgb_nxt = s1_de ? s1_rgb : 24'h000000;
`ifdef PATGEN_BORDER_EN
    if (s1_de && ((s1_x == '0) || (s1_x == vid.h_active - X_ONE) ||
                  (s1_y == '0) || (s1_y == vid.v_active - Y_BITS'(1))))
      rgb_nxt = 24'hFFFFFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_d      <= 1'b0;
      hde_d     <= 1'b0;
      pattern_q <= 3'd0;
      frame_pos <= '0;
      bar_cnt   <= '0;
      bar_idx   <= 3'd0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_de     <= 1'b0;
      s1_rgb    <= 24'h000000;
`ifdef PATGEN_BORDER_EN
      s1_x      <= '0;
      s1_y      <= '0;
`endif
      vid.r_out  <= 8'h00;
      vid.g_out  <= 8'h00;
      vid.b_out  <= 8'h00;
      vid.hs_out <= 1'b0;
      vid.vs_out <= 1'b0;
      vid.de_out <= 1'b0;
    end else begin
      vs_d  <= vid.vs_in;
      hde_d <= vid.hde_in;
      if (frame_start) begin
        pattern_q <= vid.pattern_sel;
        frame_pos <= (fpos_inc >= {1'b0, vid.h_active}) ? '0 : fpos_inc[X_BITS-1:0];
      end
      if (vid.hde_in) begin
        if (cnt_cur == bar_w - X_ONE) begin
          bar_cnt <= '0;
          bar_idx <= (idx_cur == 3'd7) ? 3'd7 : idx_cur + 3'd1;
        end else begin
          bar_cnt <= cnt_cur + X_ONE;
          bar_idx <= idx_cur;
        end
      end
      s1_hs  <= vid.hs_in;
      s1_vs  <= vid.vs_in;
      s1_de  <= vid.hde_in & vid.vde_in;
      s1_rgb <= pix;
`ifdef PATGEN_BORDER_EN
      s1_x   <= vid.x_in;
      s1_y   <= vid.y_in;
`endif
      vid.r_out  <= rgb_nxt[23:16];
      vid.g_out  <= rgb_nxt[15:8];
      vid.b_out  <= rgb_nxt[7:0];
      vid.hs_out <= s1_hs;
      vid.vs_out <= s1_vs;
      vid.de_out <= s1_de;
    end
  end
endmodule
